// File: rtl/alu16_ctl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu16_ctl
//  Purpose  : Sequencing front end for the external 16-bit adder/logic
//             device. Latches operands from the data bus, decodes a 3-bit
//             op into the adder FUNC/C_IN/B controls, holds the adder pins
//             stable for a two-cycle window (DRIVE, SETTLE) and then
//             captures the adder result with carry and zero flags.
//  Ports    : clk, reset            - clock, asynchronous active-high reset
//             din, load_a, load_b   - operand loads (accepted in IDLE only)
//             start, op             - launch op (accepted in IDLE only)
//             busy, done            - status; done is a one-cycle pulse
//             result, carry, zero   - registered result and flags
//             alu_a/alu_b/alu_cin/alu_func - adder device inputs
//             alu_out, alu_cout     - adder device outputs
//  Revision : 1.0 - initial release
// ============================================================================
module alu16_ctl (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic        load_a,
  input  logic        load_b,
  input  logic        start,
  input  logic [2:0]  op,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        carry,
  output logic        zero,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  output logic [1:0]  alu_func,
  input  logic [15:0] alu_out,
  input  logic        alu_cout
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADC  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SBC  = 3'd3;
  localparam logic [2:0] OP_INC  = 3'd4;
  localparam logic [2:0] OP_ANDN = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_NOT  = 3'd7;

  localparam logic [1:0] FUNC_ADD  = 2'b00;
  localparam logic [1:0] FUNC_ANDN = 2'b01;
  localparam logic [1:0] FUNC_OR   = 2'b10;
  localparam logic [1:0] FUNC_NOT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [2:0]  r_op;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: a fixed two-cycle pin window after START
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nx = ST_DRIVE;
      ST_DRIVE:  w_state_nx = ST_SETTLE;
      ST_SETTLE: w_state_nx = ST_IDLE;
      default:   w_state_nx = ST_IDLE;
    endcase
  end

  assign busy = (r_state != ST_IDLE);

  // --------------------------------------------------------------------------
  // Operand/op registers, capture and done pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= OP_ADD;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b1;
      done   <= 1'b0;
    end else begin
      // Loads and START share the edge; the adder pins come from the
      // registers afterwards, so a same-edge load is seen by the op.
      if (r_state == ST_IDLE) begin
        if (load_a) r_a  <= din;
        if (load_b) r_b  <= din;
        if (start)  r_op <= op;
      end

      done <= (r_state == ST_SETTLE);

      if (r_state == ST_SETTLE) begin
        result <= alu_out;
        zero   <= (alu_out == 16'h0000);
        // Logic ops leave the carry chain untouched so a multiword
        // sequence can interleave them.
        if (r_op <= OP_INC) carry <= alu_cout;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Adder pin decode from the latched op. Carry is frozen while busy, so
  // feeding it straight to C_IN gives the value seen when START was sampled.
  // --------------------------------------------------------------------------
  assign alu_a = r_a;

  always_comb begin
    alu_func = FUNC_ADD;
    alu_b    = r_b;
    alu_cin  = 1'b0;
    case (r_op)
      OP_ADD:  begin alu_func = FUNC_ADD;  alu_b = r_b;    alu_cin = 1'b0;  end
      OP_ADC:  begin alu_func = FUNC_ADD;  alu_b = r_b;    alu_cin = carry; end
      OP_SUB:  begin alu_func = FUNC_ADD;  alu_b = ~r_b;   alu_cin = 1'b1;  end
      OP_SBC:  begin alu_func = FUNC_ADD;  alu_b = ~r_b;   alu_cin = carry; end
      OP_INC:  begin alu_func = FUNC_ADD;  alu_b = 16'h0;  alu_cin = 1'b1;  end
      OP_ANDN: begin alu_func = FUNC_ANDN; alu_b = r_b;    alu_cin = 1'b0;  end
      OP_OR:   begin alu_func = FUNC_OR;   alu_b = r_b;    alu_cin = 1'b0;  end
      OP_NOT:  begin alu_func = FUNC_NOT;  alu_b = r_b;    alu_cin = 1'b0;  end
      default: begin alu_func = FUNC_ADD;  alu_b = r_b;    alu_cin = 1'b0;  end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu16_ctl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu16_ctl
//  Purpose  : Self-checking bench for alu16_ctl paired with a behavioural
//             model of the 16-bit adder device. Expected results come from
//             plain integer arithmetic on the operands and the carry flag.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu16_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        load_a, load_b, start;
  logic [2:0]  op;
  logic        busy, done, carry, zero;
  logic [15:0] result, alu_a, alu_b, alu_out;
  logic        alu_cin, alu_cout;
  logic [1:0]  alu_func;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [15:0] m_a, m_b, m_result;
  logic        m_carry, m_zero;

  always #5 clk = ~clk;

  alu16_ctl dut (
    .clk(clk), .reset(reset), .din(din), .load_a(load_a), .load_b(load_b),
    .start(start), .op(op), .busy(busy), .done(done), .result(result),
    .carry(carry), .zero(zero), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_func(alu_func), .alu_out(alu_out),
    .alu_cout(alu_cout)
  );

  // adder device: combinational, 17-bit add or bitwise logic
  logic [16:0] dev_sum;
  assign dev_sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_cin};
  always_comb begin
    alu_out  = '0;
    alu_cout = 1'b0;
    case (alu_func)
      2'b00: {alu_cout, alu_out} = dev_sum;
      2'b01: alu_out = alu_a & ~alu_b;
      2'b10: alu_out = alu_a | alu_b;
      default: alu_out = ~alu_b;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load_a(input logic [15:0] v);
    din = v; load_a = 1'b1; tick(); load_a = 1'b0; m_a = v;
  endtask

  task automatic do_load_b(input logic [15:0] v);
    din = v; load_b = 1'b1; tick(); load_b = 1'b0; m_b = v;
  endtask

  // Launch one op; returns right after the capture edge (E2) with DONE high.
  // The caller's next edge is E3.
  task automatic run_op(input logic [2:0] o, input bit same_load_a,
                        input logic [15:0] va, input bit junk);
    logic [15:0] e_b, e_r;
    logic        e_cin, e_c;
    logic [1:0]  e_f;
    int          ai, bi, ci, s;
    start = 1'b1; op = o;
    if (same_load_a) begin load_a = 1'b1; din = va; m_a = va; end
    tick();                                   // E0
    start = 1'b0; load_a = 1'b0; op = 3'd0;

    // expected pin decode
    e_f = 2'b00; e_b = m_b; e_cin = 1'b0;
    case (o)
      3'd1: e_cin = m_carry;
      3'd2: begin e_b = ~m_b; e_cin = 1'b1; end
      3'd3: begin e_b = ~m_b; e_cin = m_carry; end
      3'd4: begin e_b = 16'h0; e_cin = 1'b1; end
      3'd5: e_f = 2'b01;
      3'd6: e_f = 2'b10;
      3'd7: e_f = 2'b11;
      default: ;
    endcase

    check("busy_e0", 32'(busy), 32'd1);
    check("done_e0", 32'(done), 32'd0);
    check("func_drive", 32'(alu_func), 32'(e_f));

    if (junk) begin
      start = 1'b1; load_a = 1'b1; load_b = 1'b1;
      din = 16'($urandom); op = 3'($urandom);
    end
    tick();                                   // E1, now in SETTLE
    check("busy_e1", 32'(busy), 32'd1);
    check("done_e1", 32'(done), 32'd0);
    check("alu_a", 32'(alu_a), 32'(m_a));
    check("alu_b", 32'(alu_b), 32'(e_b));
    check("alu_cin", 32'(alu_cin), 32'(e_cin));
    check("alu_func", 32'(alu_func), 32'(e_f));
    check("result_hold", 32'(result), 32'(m_result));
    check("carry_hold", 32'(carry), 32'(m_carry));

    tick();                                   // E2, capture
    if (junk) begin
      start = 1'b0; load_a = 1'b0; load_b = 1'b0; op = 3'd0;
    end

    // reference arithmetic
    ai = int'(m_a); bi = int'(m_b); ci = m_carry ? 1 : 0;
    e_c = m_carry;
    case (o)
      3'd0: begin s = ai + bi;        e_r = s[15:0]; e_c = (s > 65535); end
      3'd1: begin s = ai + bi + ci;   e_r = s[15:0]; e_c = (s > 65535); end
      3'd2: begin s = ai - bi;        e_r = s[15:0]; e_c = (s >= 0);    end
      3'd3: begin s = ai - bi - (1 - ci); e_r = s[15:0]; e_c = (s >= 0); end
      3'd4: begin s = ai + 1;         e_r = s[15:0]; e_c = (s > 65535); end
      3'd5: e_r = m_a & ~m_b;
      3'd6: e_r = m_a | m_b;
      default: e_r = ~m_b;
    endcase
    m_result = e_r; m_carry = e_c; m_zero = (e_r == 16'h0);

    check("done_e2", 32'(done), 32'd1);
    check("busy_e2", 32'(busy), 32'd0);
    check("result", 32'(result), 32'(m_result));
    check("carry", 32'(carry), 32'(m_carry));
    check("zero", 32'(zero), 32'(m_zero));
  endtask

  initial begin
    reset = 1'b1; din = '0; load_a = 0; load_b = 0; start = 0; op = '0;
    m_a = 0; m_b = 0; m_result = 0; m_carry = 0; m_zero = 1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_result", 32'(result), 32'h0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_func", 32'(alu_func), 32'd0);
    check("rst_cin", 32'(alu_cin), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);

    // reset during SETTLE aborts the op
    do_load_a(16'h0001); do_load_b(16'h0002);
    start = 1'b1; op = 3'd0; tick(); start = 1'b0;
    tick();                                   // now in SETTLE
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_alu_a", 32'(alu_a), 32'd0);
    tick();
    reset = 1'b0; m_a = 0; m_b = 0;
    tick(); tick();
    check("abort_done_later", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_busy_later", 32'(busy), 32'd0);

    // multiword carry chain
    do_load_a(16'hFFFF); do_load_b(16'h0001);
    run_op(3'd0, 0, 16'h0, 0);
    check("add_res_lit", 32'(result), 32'h0000);
    check("add_c_lit", 32'(carry), 32'd1);
    tick();
    check("done_e3", 32'(done), 32'd0);
    do_load_a(16'h0000); do_load_b(16'h0000);
    run_op(3'd1, 0, 16'h0, 0);
    check("adc_res_lit", 32'(result), 32'h0001);

    // subtraction with borrow
    do_load_a(16'h0005); do_load_b(16'h0003);
    run_op(3'd2, 0, 16'h0, 0);
    check("sub1_lit", 32'(result), 32'h0002);
    do_load_a(16'h0003); do_load_b(16'h0005);
    run_op(3'd2, 0, 16'h0, 0);
    check("sub2_lit", 32'(result), 32'hFFFE);
    do_load_a(16'h0000); do_load_b(16'h0000);
    run_op(3'd3, 0, 16'h0, 0);
    check("sbc_lit", 32'(result), 32'hFFFF);
    check("sbc_c_lit", 32'(carry), 32'd0);

    // logic ops with carry preset to 1
    do_load_a(16'h0005); do_load_b(16'h0003);
    run_op(3'd2, 0, 16'h0, 0);
    do_load_a(16'hF0F0); do_load_b(16'hFF00);
    run_op(3'd5, 0, 16'h0, 0);
    check("andn_lit", 32'(result), 32'h00F0);
    run_op(3'd6, 0, 16'h0, 0);
    check("or_lit", 32'(result), 32'hFFF0);
    run_op(3'd7, 0, 16'h0, 0);
    check("not_lit", 32'(result), 32'h00FF);
    check("logic_carry_lit", 32'(carry), 32'd1);

    // increment
    do_load_a(16'h7FFF);
    run_op(3'd4, 0, 16'h0, 0);
    check("inc1_lit", 32'(result), 32'h8000);
    do_load_a(16'hFFFF);
    run_op(3'd4, 0, 16'h0, 0);
    check("inc2_zero_lit", 32'(zero), 32'd1);

    // same-edge LOAD_A and START
    do_load_b(16'h0001);
    run_op(3'd0, 1, 16'h1234, 0);
    check("same_edge_lit", 32'(result), 32'h1235);

    // inputs during BUSY are ignored
    run_op(3'd6, 0, 16'h0, 1);
    tick();
    check("junk_done_e3", 32'(done), 32'd0);
    check("junk_busy_e3", 32'(busy), 32'd0);
    tick();
    check("junk_alu_a", 32'(alu_a), 32'(m_a));
    check("junk_result", 32'(result), 32'(m_result));
    check("junk_done_once", 32'(done), 32'd0);

    // back-to-back START at E3
    do_load_a(16'h1000); do_load_b(16'h0234);
    run_op(3'd0, 0, 16'h0, 0);
    run_op(3'd2, 0, 16'h0, 0);
    run_op(3'd1, 0, 16'h0, 0);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) do_load_a(16'($urandom));
      if ($urandom_range(0, 3) != 0) do_load_b(16'($urandom));
      run_op(3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), 16'($urandom),
             bit'($urandom_range(0, 1)));
      if (!$urandom_range(0, 1)) tick();
    end
    tick();
    check("final_done", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
